// File: rtl/seq_pkg.sv
// Shared encodings for the fetch/decode/execute sequencer: opcodes, ALU
// operation codes and FSM states.
package seq_pkg;

  localparam int PC_W_DEF = 8;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASSA = 3'd0;
  localparam logic [2:0] ALU_PASSB = 3'd1;
  localparam logic [2:0] ALU_ADD   = 3'd2;
  localparam logic [2:0] ALU_SUB   = 3'd3;
  localparam logic [2:0] ALU_AND   = 3'd4;
  localparam logic [2:0] ALU_OR    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_OPERAND = 3'd3,
    ST_SELECT  = 3'd4,
    ST_EXEC    = 3'd5,
    ST_HALT    = 3'd6
  } state_e;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode classifier, shared by the DECODE, OPERAND and EXEC
// steps of the sequencer.
module seq_decode
  import seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       two_byte,
  output logic       is_alu,
  output logic [2:0] alu_op,
  output logic       is_jump,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    two_byte   = 1'b0;
    is_alu     = 1'b0;
    alu_op     = ALU_PASSA;
    is_jump    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP: ;
      // LDI is a two-byte op that ends in EXEC passing the immediate through B
      OP_LDI: begin two_byte = 1'b1; alu_op = ALU_PASSB; end
      OP_ADD: begin is_alu = 1'b1; alu_op = ALU_ADD; end
      OP_SUB: begin is_alu = 1'b1; alu_op = ALU_SUB; end
      OP_AND: begin is_alu = 1'b1; alu_op = ALU_AND; end
      OP_OR:  begin is_alu = 1'b1; alu_op = ALU_OR;  end
      OP_JMP: begin two_byte = 1'b1; is_jump = 1'b1; end
      OP_JZ:  begin two_byte = 1'b1; is_jump = 1'b1; end
      OP_HLT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// Fetch/decode/execute sequencer driving ROM address, DataSelect, register
// file, ALU opcode and accumulator strobe. Optional macro SEQ_SINGLE_STEP_EN.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int              PC_W   = PC_W_DEF,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic            run,
  input  logic [7:0]      rom_data,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic            sel_b,
  output logic [3:0]      reg_addr,
  output logic [2:0]      alu_op,
  output logic            acc_we,
  output logic            halted,
  output logic            illegal
);

  state_e          state, state_nxt;
  logic [7:0]      ir, ir_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            sel_b_nxt, acc_we_nxt, halted_nxt, illegal_nxt;
  logic [3:0]      reg_addr_nxt;
  logic [2:0]      alu_op_nxt;
  logic            fetch_go;

  logic       dec_two_byte, dec_is_alu, dec_is_jump, dec_is_halt, dec_is_illegal;
  logic [2:0] dec_alu_op;

  seq_decode u_decode (
    .opcode     (ir[7:4]),
    .two_byte   (dec_two_byte),
    .is_alu     (dec_is_alu),
    .alu_op     (dec_alu_op),
    .is_jump    (dec_is_jump),
    .is_halt    (dec_is_halt),
    .is_illegal (dec_is_illegal)
  );

`ifdef SEQ_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RST_PC;
      ir       <= '0;
      sel_b    <= 1'b0;
      reg_addr <= '0;
      alu_op   <= ALU_PASSA;
      acc_we   <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      sel_b    <= sel_b_nxt;
      reg_addr <= reg_addr_nxt;
      alu_op   <= alu_op_nxt;
      acc_we   <= acc_we_nxt;
      halted   <= halted_nxt;
      illegal  <= illegal_nxt;
    end
  end

  // alu_op/acc_we default to idle so they are only live during the EXEC cycle
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir;
    sel_b_nxt    = sel_b;
    reg_addr_nxt = reg_addr;
    alu_op_nxt   = ALU_PASSA;
    acc_we_nxt   = 1'b0;
    halted_nxt   = halted;
    illegal_nxt  = illegal;
    case (state)
      ST_IDLE: if (run) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (!run) begin
          state_nxt = ST_IDLE;
        end else if (fetch_go) begin
          ir_nxt    = rom_data;
          pc_nxt    = pc + 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_two_byte) begin
          state_nxt = ST_OPERAND;
        end else if (dec_is_alu) begin
          reg_addr_nxt = ir[3:0];
          sel_b_nxt    = 1'b0;
          state_nxt    = ST_SELECT;
        end else if (dec_is_halt) begin
          halted_nxt = 1'b1;
          state_nxt  = ST_HALT;
        end else begin
          if (dec_is_illegal) illegal_nxt = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_OPERAND: begin
        // zero is taken as-is: it already reflects the most recent EXEC
        if (dec_is_jump) begin
          if (ir[7:4] == OP_JZ && !zero) pc_nxt = pc + 1'b1;
          else                           pc_nxt = PC_W'(rom_data);
          state_nxt = ST_FETCH;
        end else begin
          pc_nxt    = pc + 1'b1;
          sel_b_nxt = 1'b1;
          state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        alu_op_nxt = dec_alu_op;
        acc_we_nxt = 1'b1;
        state_nxt  = ST_EXEC;
      end
      ST_EXEC: begin
        sel_b_nxt = 1'b0;
        state_nxt = ST_FETCH;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: ROM model, scoreboard of expected EXEC
// strobes, and directed programs.
module tb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       zero = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step = 1'b0;
`endif
  logic [7:0] rom_data;
  logic [7:0] pc;
  logic       sel_b;
  logic [3:0] reg_addr;
  logic [2:0] alu_op;
  logic       acc_we;
  logic       halted;
  logic       illegal;

  logic [7:0] rom [256];
  assign rom_data = rom[pc];

  int errors = 0;
  int checks = 0;

  // expected EXEC strobe contents: {alu_op, sel_b, reg_addr}
  logic [7:0] sb [$];

  seq_ctrl #(.PC_W(8), .RST_PC(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SEQ_SINGLE_STEP_EN
    .step     (step),
`endif
    .run      (run),
    .rom_data (rom_data),
    .zero     (zero),
    .pc       (pc),
    .sel_b    (sel_b),
    .reg_addr (reg_addr),
    .alu_op   (alu_op),
    .acc_we   (acc_we),
    .halted   (halted),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (acc_we) begin
      if (sb.size() == 0) begin
        check("unexpected_acc_we", int'(acc_we), 0);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("exec_strobe", int'({alu_op, sel_b, reg_addr}), int'(e));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_with_rom_cleared();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    zero  = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;

    // LDI 0x05: reset state, then PASSB with immediate select in EXEC
    reset_with_rom_cleared();
    rst_n = 1'b0;
    rom[0] = 8'h10; rom[1] = 8'h05;
    cycles(1);
    check("rst_pc", pc, 0);
    check("rst_sel_b", sel_b, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_acc_we", acc_we, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    run = 1'b1;
    sb.push_back({3'd1, 1'b1, 4'd0});
    cycles(2);
    check("ldi_pc_decode", pc, 1);
    cycles(2);
    check("ldi_pc_select", pc, 2);
    check("ldi_sel_b_select", sel_b, 1);
    check("ldi_we_select", acc_we, 0);
    cycles(1);
    check("ldi_we_exec", acc_we, 1);
    check("ldi_op_exec", alu_op, 1);
    cycles(1);
    check("ldi_we_after", acc_we, 0);
    check("ldi_op_after", alu_op, 0);
    check("ldi_sel_b_after", sel_b, 0);
    run = 1'b0;
    cycles(3);

    // ADD R3 with run dropped while in DECODE: completes, then idles at pc=1
    reset_with_rom_cleared();
    rom[0] = 8'h23;
    run = 1'b1;
    sb.push_back({3'd2, 1'b0, 4'd3});
    cycles(2);
    run = 1'b0;
    cycles(1);
    check("add_reg_addr_select", reg_addr, 3);
    check("add_sel_b_select", sel_b, 0);
    check("add_we_select", acc_we, 0);
    cycles(1);
    check("add_we_exec", acc_we, 1);
    check("add_op_exec", alu_op, 2);
    cycles(6);
    check("add_idle_pc", pc, 1);
    check("add_idle_we", acc_we, 0);

    // JZ taken and not taken
    reset_with_rom_cleared();
    rom[0] = 8'h70; rom[1] = 8'h40;
    zero = 1'b1;
    run = 1'b1;
    cycles(4);
    check("jz_taken_pc", pc, 8'h40);
    run = 1'b0;
    cycles(2);
    reset_with_rom_cleared();
    rom[0] = 8'h70; rom[1] = 8'h40;
    zero = 1'b0;
    run = 1'b1;
    cycles(4);
    check("jz_not_taken_pc", pc, 2);
    run = 1'b0;
    cycles(2);

    // JMP 0xFF then NOP fetch wraps pc
    reset_with_rom_cleared();
    rom[0] = 8'h60; rom[1] = 8'hFF;
    run = 1'b1;
    cycles(4);
    check("jmp_pc", pc, 8'hFF);
    cycles(1);
    check("pc_wrap", pc, 0);
    run = 1'b0;
    cycles(2);

    // illegal opcode then HLT: sticky flags, frozen state, async clear
    reset_with_rom_cleared();
    rom[0] = 8'h90; rom[1] = 8'hF0;
    run = 1'b1;
    cycles(3);
    check("illegal_set", illegal, 1);
    check("illegal_not_halted", halted, 0);
    cycles(2);
    check("halted_set", halted, 1);
    check("halted_pc", pc, 2);
    for (int i = 0; i < 24; i++) begin
      run = 1'($urandom_range(0, 1));
      cycles(1);
    end
    check("halt_frozen_pc", pc, 2);
    check("halt_sticky", halted, 1);
    check("illegal_sticky", illegal, 1);
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    check("halt_async_clear", halted, 0);
    check("illegal_async_clear", illegal, 0);
    check("halt_rst_pc", pc, 0);
    cycles(2);
    rst_n = 1'b1;

    // reset asserted during SELECT aborts the ADD with no strobe
    reset_with_rom_cleared();
    rom[0] = 8'h23;
    run = 1'b1;
    cycles(3);
    check("abort_reg_addr_select", reg_addr, 3);
    rst_n = 1'b0;
    #1;
    check("abort_reg_addr_clear", reg_addr, 0);
    check("abort_we_clear", acc_we, 0);
    check("abort_pc_clear", pc, 0);
    run = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(6);
    check("abort_no_we", acc_we, 0);
    run = 1'b1;
    sb.push_back({3'd2, 1'b0, 4'd3});
    cycles(4);
    check("rerun_we_exec", acc_we, 1);
    run = 1'b0;
    cycles(4);

`ifdef SEQ_SINGLE_STEP_EN
    // single step: FETCH holds without step, one pulse runs one instruction
    reset_with_rom_cleared();
    rom[0] = 8'h23; rom[1] = 8'h23;
    run = 1'b1;
    step = 1'b0;
    cycles(10);
    check("step_hold_pc", pc, 0);
    sb.push_back({3'd2, 1'b0, 4'd3});
    step = 1'b1;
    cycles(1);
    step = 1'b0;
    cycles(12);
    check("step_one_instr_pc", pc, 1);
    run = 1'b0;
    cycles(2);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
- Fetch/decode/execute sequencer for the 8-bit datapath.
- Addresses the program ROM and drives the DataSelect control (`Ctl`, i.e. B-operand source: register file vs ROM immediate), the register-file read address, the ALU opcode and the accumulator write strobe.
- Sits between program ROM, register file, DataSelect and ALU.
- Every output is registered.

Parameters:
- PC_W, 8, program counter / ROM address width.
- RST_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = sequencer may leave IDLE/FETCH
- rom_data  in  8  ROM byte at address pc, combinational ROM, valid same cycle
- zero  in  1  ALU zero flag, registered in ALU, valid in EXEC cycle
- pc  out  PC_W  ROM address
- sel_b  out  1  to DataSelect Ctl: 0 = register-file Db, 1 = romx immediate
- reg_addr  out  4  register-file read address (drives Db)
- alu_op  out  3  0 NOP/PASSA, 1 PASSB, 2 ADD, 3 SUB, 4 AND, 5 OR
- acc_we  out  1  one-cycle accumulator write strobe
- halted  out  1  sticky HLT indication
- illegal  out  1  sticky, set on undefined opcode

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RST_PC, ir=0, imm=0.
  - sel_b=0, reg_addr=0, alu_op=0, acc_we=0, halted=0, illegal=0.
- Instruction format: ir[7:4] opcode, ir[3:0] register index.
  - 0x0 NOP
  - 0x1 LDI imm (2 bytes)
  - 0x2 ADD Rn
  - 0x3 SUB Rn
  - 0x4 AND Rn
  - 0x5 OR Rn
  - 0x6 JMP imm (2 bytes)
  - 0x7 JZ imm (2 bytes)
  - 0xF HLT
  - others illegal.
- States: IDLE, FETCH, DECODE, OPERAND, SELECT, EXEC, HALT.
- IDLE: run=1 → FETCH; else stay.
- FETCH: run=0 → IDLE (pc unchanged). Otherwise ir<=rom_data, pc<=pc+1 (wraps modulo 2^PC_W) → DECODE.
- DECODE:
  - LDI/JMP/JZ → OPERAND.
  - ALU ops → SELECT, with reg_addr<=ir[3:0], sel_b<=0.
  - NOP → FETCH.
  - HLT → HALT, halted<=1.
  - Illegal → illegal<=1, treated as NOP → FETCH.
- OPERAND: imm<=rom_data, pc<=pc+1.
  - JMP: pc<=imm source (rom_data) instead, → FETCH.
  - JZ: if zero=1, pc<=rom_data; else pc+1. → FETCH.
  - LDI: sel_b<=1 → SELECT.
- SELECT: one cycle for DataSelect to register the B operand (DataSelect latency = 1 clk) → EXEC.
- EXEC:
  - alu_op from opcode (LDI→PASSB, ADD→2, SUB→3, AND→4, OR→5); acc_we<=1 for exactly one cycle → FETCH.
  - alu_op and sel_b return to 0 the cycle after acc_we.
- Cycles per instruction:
  - NOP/illegal: 2.
  - ALU Rn: 4.
  - LDI: 5.
  - JMP/JZ: 3.
- HALT: absorbing; only rst_n exits. run ignored.
- JZ samples the zero produced by the last EXEC; zero is not re-evaluated inside the sequencer.
- run deassert takes effect only at FETCH; an instruction in flight always completes.
- Reset mid-instruction: aborts immediately, no acc_we pulse after rst_n rises until a full fetch completes.
- pc wrap: 0xFF+1 → 0x00 (PC_W=8), no flag.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - FETCH proceeds only when run=1 and step=1 sampled that cycle; otherwise holds in FETCH with pc stable, so one instruction executes per step pulse.
- Undefined:
  - No step port; FETCH proceeds whenever run=1.

Decomposition:
- Package seq_pkg:
  - opcode localparams (OP_NOP..OP_HLT).
  - alu_op encodings (ALU_PASSA..ALU_OR).
  - state encoding constants.
  - PC_W default.
- Sub-module seq_decode: combinational opcode → {two_byte, is_alu, alu_op, is_jump, is_halt, is_illegal}. It is shared by DECODE and EXEC logic.
- Everything else stays in seq_ctrl.

Test Plan:
- Reset with ROM {0x10,0x05} → all outputs 0, pc=0; run=1 → at EXEC sel_b=1, alu_op=1, acc_we=1 for one cycle, 5 cycles after leaving IDLE; pc=2.
- ROM {0x23} → reg_addr=3 and sel_b=0 from SELECT; alu_op=2 and acc_we in EXEC, 4th cycle of instruction.
- ROM {0x70,0x40} with zero=1 → next fetch pc=0x40. Repeat with zero=0 → next fetch pc=2.
- ROM {0x60,0xFF}, ROM[0xFF]=0x00 → pc 0xFF; after NOP fetch pc wraps to 0x00.
- ROM {0x90,0xF0} → illegal=1 after first DECODE, execution continues; halted=1 and state frozen for ≥20 cycles with run toggling; rst_n low clears both.
- Drop run mid-ADD → ADD completes with acc_we pulse, then IDLE with pc=1. Assert rst_n=0 during SELECT → outputs clear asynchronously, no acc_we. With SEQ_SINGLE_STEP_EN, run=1 step=0 → pc frozen; single step pulse → exactly one instruction.
